// File: rtl/sram_controller.sv
// Sequences a 32-bit MEM-stage load/store as two 16-bit accesses on an external async SRAM.
// While an access is in flight, ready is held low so the pipeline freezes.
module sram_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEMwrite,
    input  logic        MEMread,
    input  logic [31:0] address,
    input  logic [31:0] data,
    output logic [31:0] MEM_result,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_WE_N
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] mem_result_q, mem_result_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic [15:0] dq_out_q, dq_out_d;

    logic        request;
    logic        last_cnt;
    logic        half_sel;
    logic [31:0] offset;
    logic [16:0] word;
    logic        unused_offset_bits;

    assign request            = MEMread | MEMwrite;
    assign last_cnt           = (cnt_q == LAST_CNT);
    assign offset             = address - BASE_ADDR;
    assign word               = offset[18:2];
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
    assign MEM_result         = mem_result_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_wr_d      = is_wr_q;
        mem_result_d = mem_result_q;
        half_sel     = 1'b0;
        ready        = 1'b0;
        SRAM_ADDR    = sram_addr_q;
        SRAM_DQ_out  = dq_out_q;
        SRAM_DQ_oe   = 1'b0;
        SRAM_WE_N    = 1'b1;

        case (state_q)
            S_IDLE: begin
                ready = ~request;
                if (request) begin
                    state_d = S_LOW;
                    cnt_d   = 4'd0;
                    // A simultaneous read+write is treated as a write.
                    is_wr_d = MEMwrite;
                end
            end
            S_LOW, S_HIGH: begin
                half_sel  = (state_q == S_HIGH);
                SRAM_ADDR = {word, half_sel};
                if (is_wr_q) begin
                    SRAM_DQ_oe  = 1'b1;
                    SRAM_DQ_out = half_sel ? data[31:16] : data[15:0];
                    // Release WE_N on the final count so addr/data outlive its rising edge.
                    SRAM_WE_N   = last_cnt;
                end
                if (last_cnt) begin
                    cnt_d   = 4'd0;
                    state_d = half_sel ? S_DONE : S_HIGH;
                    if (!is_wr_q) begin
                        if (half_sel) begin
                            mem_result_d[31:16] = SRAM_DQ_in;
                        end else begin
                            mem_result_d[15:0] = SRAM_DQ_in;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sram_addr_d = SRAM_ADDR;
        dq_out_d    = SRAM_DQ_out;

        if (rst) begin
            ready = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            is_wr_q      <= 1'b0;
            mem_result_q <= 32'd0;
            sram_addr_q  <= 18'd0;
            dq_out_q     <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_wr_q      <= is_wr_d;
            mem_result_q <= mem_result_d;
            sram_addr_q  <= sram_addr_d;
            dq_out_q     <= dq_out_d;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: two instances (WAIT_CYCLES 2 and 3), each with an SRAM
// model; expected read results go through a scoreboard queue.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst, rst3;
    logic        rd2, wr2, rd3, wr3;
    logic [31:0] address, data;

    logic [31:0] res2, res3;
    logic        ready2, ready3;
    logic [17:0] addr2, addr3;
    logic [15:0] dq_out2, dq_out3, dq_in2, dq_in3;
    logic        oe2, oe3, we2_n, we3_n;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut (
        .clk(clk), .rst(rst), .MEMwrite(wr2), .MEMread(rd2), .address(address), .data(data),
        .MEM_result(res2), .ready(ready2), .SRAM_ADDR(addr2), .SRAM_DQ_out(dq_out2),
        .SRAM_DQ_oe(oe2), .SRAM_DQ_in(dq_in2), .SRAM_WE_N(we2_n)
    );

    sram_controller #(.WAIT_CYCLES(3), .BASE_ADDR(32'd1024)) dut3 (
        .clk(clk), .rst(rst3), .MEMwrite(wr3), .MEMread(rd3), .address(address), .data(data),
        .MEM_result(res3), .ready(ready3), .SRAM_ADDR(addr3), .SRAM_DQ_out(dq_out3),
        .SRAM_DQ_oe(oe3), .SRAM_DQ_in(dq_in3), .SRAM_WE_N(we3_n)
    );

    // Async SRAM models, written while WE_N is low.
    logic [15:0] sram2 [0:1023];
    logic [15:0] sram3 [0:1023];
    always @(posedge clk) if (!we2_n) sram2[addr2[9:0]] <= dq_out2;
    always @(posedge clk) if (!we3_n) sram3[addr3[9:0]] <= dq_out3;
    assign dq_in2 = sram2[addr2[9:0]];
    assign dq_in3 = sram3[addr3[9:0]];

    int          sel;
    logic [31:0] obs_res;
    logic        obs_ready, obs_oe, obs_we_n;
    logic [17:0] obs_addr;
    logic [15:0] obs_dq;

    always_comb begin
        obs_res   = (sel == 0) ? res2 : res3;
        obs_ready = (sel == 0) ? ready2 : ready3;
        obs_oe    = (sel == 0) ? oe2 : oe3;
        obs_we_n  = (sel == 0) ? we2_n : we3_n;
        obs_addr  = (sel == 0) ? addr2 : addr3;
        obs_dq    = (sel == 0) ? dq_out2 : dq_out3;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb [$];
    logic [31:0] model [int];
    logic [31:0] last_res [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called just after a rising edge; returns just after the rising edge following DONE.
    task automatic run_access(input int s, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] dat);
        int          w;
        int          cnt;
        logic        hi;
        logic [16:0] word;
        logic [31:0] exp_res;
        logic [31:0] offs;
        int          key;
        w    = (s == 0) ? 2 : 3;
        offs = addr - 32'd1024;
        word = offs[18:2];
        key  = s * 262144 + int'(word);
        if (rd && !wr) exp_res = model.exists(key) ? model[key] : 32'd0;
        else           exp_res = last_res[s];
        if (wr) model[key] = dat;
        last_res[s] = exp_res;
        sb.push_back(exp_res);

        sel     = s;
        address = addr;
        data    = dat;
        if (s == 0) begin rd2 = rd; wr2 = wr; end
        else        begin rd3 = rd; wr3 = wr; end

        for (int k = 0; k <= 2 * w + 1; k++) begin
            @(negedge clk);
            check("ready", 32'(obs_ready), 32'(k == 2 * w + 1));
            if (k >= 1 && k <= 2 * w) begin
                hi  = (k > w);
                cnt = hi ? k - w - 1 : k - 1;
                check("sram_addr", 32'(obs_addr), 32'({word, hi}));
                check("dq_oe", 32'(obs_oe), 32'(wr));
                check("we_n", 32'(obs_we_n), wr ? 32'(cnt == w - 1) : 32'd1);
                if (wr) check("dq_out", 32'(obs_dq), hi ? 32'(dat[31:16]) : 32'(dat[15:0]));
            end else begin
                check("we_n_idle", 32'(obs_we_n), 32'd1);
                check("dq_oe_idle", 32'(obs_oe), 32'd0);
            end
            if (k == 2 * w + 1) check("mem_result", obs_res, sb.pop_front());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycle();
        rd2 = 1'b0; wr2 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(obs_ready), 32'd1);
        check("idle_we_n", 32'(obs_we_n), 32'd1);
        check("idle_oe", 32'(obs_oe), 32'd0);
        check("idle_result", obs_res, last_res[sel]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        sel = 0;
        last_res[0] = 32'd0;
        last_res[1] = 32'd0;
        rst = 1'b1; rst3 = 1'b1;
        rd2 = 1'b1; wr2 = 1'b0; rd3 = 1'b1; wr3 = 1'b0;
        address = 32'd1028; data = 32'd0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(ready2), 32'd1);
            check("rst_we_n", 32'(we2_n), 32'd1);
            check("rst_oe", 32'(oe2), 32'd0);
            check("rst_result", res2, 32'd0);
            check("rst_ready3", 32'(ready3), 32'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; rst3 = 1'b0;
        rd2 = 1'b0; rd3 = 1'b0;

        // Write then read back, WAIT_CYCLES=2
        run_access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        idle_cycle();
        run_access(0, 1'b1, 1'b0, 32'd1028, 32'h0);
        idle_cycle();

        // Back-to-back: read presented in the IDLE cycle right after DONE
        run_access(0, 1'b0, 1'b1, 32'd1024, 32'h12345678);
        run_access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
        idle_cycle();

        // WAIT_CYCLES=3 instance, including a read+write conflict
        run_access(1, 1'b0, 1'b1, 32'd1032, 32'h11112222);
        idle_cycle();
        run_access(1, 1'b1, 1'b0, 32'd1032, 32'h0);
        idle_cycle();
        run_access(1, 1'b1, 1'b1, 32'd1032, 32'hA5A55A5A);
        idle_cycle();
        run_access(1, 1'b1, 1'b0, 32'd1032, 32'h0);
        idle_cycle();

        // Reset during the HIGH half of a write
        sel = 0;
        address = 32'd1036; data = 32'hCAFEF00D;
        wr2 = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("mid_we_n", 32'(we2_n), 32'd0);
        check("mid_addr", 32'(addr2), 32'd7);
        check("mid_result", res2, 32'h12345678);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(ready2), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr2 = 1'b0;
        last_res[0] = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("post_rst_we_n", 32'(we2_n), 32'd1);
            check("post_rst_oe", 32'(oe2), 32'd0);
            check("post_rst_result", res2, 32'd0);
            check("post_rst_ready", 32'(ready2), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
